// File: rtl/ex_mem_skid_reg.sv
// EX/MEM stage register with a valid/ready handshake and a 2-entry skid buffer.
// Also provides a synchronous flush, control masking on bubbles and a saturating stall counter.
module ex_mem_skid_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              zero_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   alu_result_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              zero_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [STAT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   rs2_data;
        logic [REG_AW-1:0] rd_addr;
        logic              zero;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state;
    entry_t            main_q;
    entry_t            skid_q;
    entry_t            in_entry;
    logic              accept;
    logic              pop;
    logic [STAT_W-1:0] stall_cnt;

    assign in_entry = {pc_i, alu_result_i, rs2_data_i, rd_addr_i, zero_i, ctrl_i};

    // Handshake flags depend only on the state register, never on out_ready_i.
    assign in_ready_o  = (state != SKID);
    assign out_valid_o = (state != EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_entry;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (accept && pop) begin
                        main_q <= in_entry;
                    end else if (pop) begin
                        state <= EMPTY;
                    end else if (accept) begin
                        skid_q <= in_entry;
                        state  <= SKID;
                    end
                end
                SKID: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (out_valid_o && !out_ready_i && !flush_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end

    assign pc_o         = main_q.pc;
    assign alu_result_o = main_q.alu_result;
    assign rs2_data_o   = main_q.rs2_data;
    assign rd_addr_o    = main_q.rd_addr;
    assign zero_o       = main_q.zero;
    assign ctrl_o       = main_q.ctrl & {CTRL_W{out_valid_o}};
    assign stall_cnt_o  = stall_cnt;

endmodule
